// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - opcodes, FSM states and control encodings for the multi-cycle controller (ILLEGAL_OP_TRAP_EN adds TRAP)
package riscv_pkg;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_S    = 7'b0100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;
  localparam logic [1:0] RES_IMMEXT    = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2    = 2'b00;
  localparam logic [1:0] SRCB_IMMEXT = 2'b01;
  localparam logic [1:0] SRCB_FOUR   = 2'b10;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b01;
  localparam logic [1:0] ALUOP_ITYPE  = 2'b10;
  localparam logic [1:0] ALUOP_BRANCH = 2'b11;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_J = 3'b010;
  localparam logic [2:0] IMM_B = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEM_ADDR,
    S_MEM_READ,
    S_MEM_WB,
    S_MEM_WRITE,
    S_EXEC_R,
    S_EXEC_I,
    S_ALU_WB,
    S_BRANCH,
    S_JALR_ADDR,
    S_JUMP,
    S_LUI_WB
`ifdef ILLEGAL_OP_TRAP_EN
    , S_TRAP
`endif
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [2:0] imm_src;
    logic       reg_write;
    logic       retire;
`ifdef ILLEGAL_OP_TRAP_EN
    logic       illegal_op;
`endif
  } ctrl_t;

endpackage

// File: rtl/mc_output_decoder.sv
// rtl/mc_output_decoder.sv - combinational state+Op to control word decode (ILLEGAL_OP_TRAP_EN adds TRAP)
module mc_output_decoder
  import riscv_pkg::*;
(
  input  state_t     state,
  input  logic [6:0] op,
  input  logic       branch_taken,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.alu_src_a  = SRCA_PC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.result_src = RES_ALURESULT;
        ctrl.ir_write   = mem_ready;
        ctrl.pc_write   = mem_ready;
      end
      S_DECODE: begin
        // branch/jump target is precomputed into ALUOut here
        ctrl.alu_src_a = SRCA_OLDPC;
        ctrl.alu_src_b = SRCB_IMMEXT;
        ctrl.imm_src   = (op == OP_JAL) ? IMM_J : IMM_B;
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a = SRCA_RD1;
        ctrl.alu_src_b = SRCB_IMMEXT;
        ctrl.imm_src   = (op == OP_S) ? IMM_S : IMM_I;
      end
      S_MEM_READ: begin
        ctrl.adr_src    = 1'b1;
        ctrl.result_src = RES_ALUOUT;
      end
      S_MEM_WB: begin
        ctrl.result_src = RES_DATA;
        ctrl.reg_write  = 1'b1;
        ctrl.retire     = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl.adr_src    = 1'b1;
        ctrl.result_src = RES_ALUOUT;
        ctrl.mem_write  = 1'b1;
        ctrl.retire     = mem_ready;
      end
      S_EXEC_R: begin
        ctrl.alu_src_a = SRCA_RD1;
        ctrl.alu_src_b = SRCB_RD2;
        ctrl.alu_op    = ALUOP_RTYPE;
      end
      S_EXEC_I: begin
        ctrl.alu_src_a = SRCA_RD1;
        ctrl.alu_src_b = SRCB_IMMEXT;
        ctrl.alu_op    = ALUOP_ITYPE;
        ctrl.imm_src   = IMM_I;
      end
      S_ALU_WB: begin
        ctrl.result_src = RES_ALUOUT;
        ctrl.reg_write  = 1'b1;
        ctrl.retire     = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a  = SRCA_RD1;
        ctrl.alu_src_b  = SRCB_RD2;
        ctrl.alu_op     = ALUOP_BRANCH;
        ctrl.result_src = RES_ALUOUT;
        ctrl.pc_write   = branch_taken;
        ctrl.retire     = 1'b1;
      end
      S_JALR_ADDR: begin
        ctrl.alu_src_a = SRCA_RD1;
        ctrl.alu_src_b = SRCB_IMMEXT;
        ctrl.imm_src   = IMM_I;
      end
      S_JUMP: begin
        // PC takes the target from ALUOut while the ALU forms OldPC+4 for the link write
        ctrl.alu_src_a  = SRCA_OLDPC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.result_src = RES_ALUOUT;
        ctrl.pc_write   = 1'b1;
      end
      S_LUI_WB: begin
        ctrl.imm_src    = IMM_U;
        ctrl.result_src = RES_IMMEXT;
        ctrl.reg_write  = 1'b1;
        ctrl.retire     = 1'b1;
      end
`ifdef ILLEGAL_OP_TRAP_EN
      S_TRAP: begin
        ctrl.illegal_op = 1'b1;
      end
`endif
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multi-cycle RV32I control FSM with retired-instruction counter (ILLEGAL_OP_TRAP_EN adds TRAP)
module multicycle_controller
  import riscv_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       Op,
  input  logic             branch_taken,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             AdrSrc,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [2:0]       ImmSrc,
  output logic             RegWrite,
  output logic             retire,
  output logic [CNT_W-1:0] instret
`ifdef ILLEGAL_OP_TRAP_EN
  , output logic           illegal_op
`endif
);

  state_t state, state_next;
  ctrl_t  ctrl;

  mc_output_decoder u_dec (
    .state        (state),
    .op           (Op),
    .branch_taken (branch_taken),
    .mem_ready    (mem_ready),
    .ctrl         (ctrl)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_FETCH;
      instret <= '0;
    end else begin
      state <= state_next;
      if (ctrl.retire)
        instret <= instret + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_FETCH:     if (mem_ready) state_next = S_DECODE;
      S_DECODE: begin
        case (Op)
          OP_LW, OP_S: state_next = S_MEM_ADDR;
          OP_R:        state_next = S_EXEC_R;
          OP_I:        state_next = S_EXEC_I;
          OP_B:        state_next = S_BRANCH;
          OP_JAL:      state_next = S_JUMP;
          OP_JALR:     state_next = S_JALR_ADDR;
          OP_LUI:      state_next = S_LUI_WB;
`ifdef ILLEGAL_OP_TRAP_EN
          default:     state_next = S_TRAP;
`else
          default:     state_next = S_FETCH;
`endif
        endcase
      end
      S_MEM_ADDR:  state_next = (Op == OP_S) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  if (mem_ready) state_next = S_MEM_WB;
      S_MEM_WRITE: if (mem_ready) state_next = S_FETCH;
      S_EXEC_R,
      S_EXEC_I:    state_next = S_ALU_WB;
      S_JALR_ADDR: state_next = S_JUMP;
      S_JUMP:      state_next = S_ALU_WB;
      S_MEM_WB,
      S_ALU_WB,
      S_BRANCH,
      S_LUI_WB:    state_next = S_FETCH;
`ifdef ILLEGAL_OP_TRAP_EN
      S_TRAP:      state_next = S_TRAP;
`endif
      default:     state_next = S_FETCH;
    endcase
  end

  // strobes are masked during reset so an in-flight write is dropped at once
  assign PCWrite   = ctrl.pc_write  & ~rst;
  assign IRWrite   = ctrl.ir_write  & ~rst;
  assign MemWrite  = ctrl.mem_write & ~rst;
  assign RegWrite  = ctrl.reg_write & ~rst;
  assign retire    = ctrl.retire    & ~rst;
  assign AdrSrc    = ctrl.adr_src;
  assign ResultSrc = ctrl.result_src;
  assign ALUSrcA   = ctrl.alu_src_a;
  assign ALUSrcB   = ctrl.alu_src_b;
  assign ALUOp     = ctrl.alu_op;
  assign ImmSrc    = ctrl.imm_src;
`ifdef ILLEGAL_OP_TRAP_EN
  assign illegal_op = ctrl.illegal_op;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - self-checking bench for multicycle_controller (honours ILLEGAL_OP_TRAP_EN)
module tb_multicycle_controller;

  localparam int W = 4;

  localparam logic [6:0] R_OP  = 7'b0110011, I_OP  = 7'b0010011, LW_OP  = 7'b0000011;
  localparam logic [6:0] S_OP  = 7'b0100011, B_OP  = 7'b1100011, JAL_OP = 7'b1101111;
  localparam logic [6:0] JR_OP = 7'b1100111, LUI_OP = 7'b0110111, BAD_OP = 7'b1111111;

  logic clk = 1'b0;
  logic rst, branch_taken, mem_ready;
  logic [6:0] Op;
  logic PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, retire;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
  logic [2:0] ImmSrc;
  logic [W-1:0] instret;
`ifdef ILLEGAL_OP_TRAP_EN
  logic illegal_op;
`endif

  multicycle_controller #(.CNT_W(W)) dut (
    .clk(clk), .rst(rst), .Op(Op), .branch_taken(branch_taken), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .ImmSrc(ImmSrc), .RegWrite(RegWrite), .retire(retire), .instret(instret)
`ifdef ILLEGAL_OP_TRAP_EN
    , .illegal_op(illegal_op)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic pcw, adr, memw, irw;
    logic [1:0] rs, as, bs, ao;
    logic [2:0] imm;
    logic regw, ret;
  } ctl_t;

  typedef struct {
    logic [6:0] op;
    logic mr, bt, ill;
    ctl_t e;
  } cyc_t;

  cyc_t q[$];
  int errors = 0;
  int checks = 0;
  int cnt = 0;
  int r;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // per-phase control words as listed for each step of an instruction
  function automatic ctl_t p_fetch(logic mr);
    ctl_t c = '0; c.pcw = mr; c.irw = mr; c.rs = 2'b10; c.bs = 2'b10; return c;
  endfunction
  function automatic ctl_t p_decode(logic [6:0] op);
    ctl_t c = '0; c.as = 2'b01; c.bs = 2'b01; c.imm = (op == JAL_OP) ? 3'b010 : 3'b011; return c;
  endfunction
  function automatic ctl_t p_addr(logic [6:0] op);
    ctl_t c = '0; c.as = 2'b10; c.bs = 2'b01; c.imm = (op == S_OP) ? 3'b001 : 3'b000; return c;
  endfunction
  function automatic ctl_t p_wb(logic [1:0] rs);
    ctl_t c = '0; c.rs = rs; c.regw = 1'b1; c.ret = 1'b1; if (rs == 2'b11) c.imm = 3'b100; return c;
  endfunction
  function automatic ctl_t p_alu(logic [1:0] as, logic [1:0] bs, logic [1:0] ao, logic [2:0] imm);
    ctl_t c = '0; c.as = as; c.bs = bs; c.ao = ao; c.imm = imm; return c;
  endfunction

  task automatic push(input logic [6:0] op, input logic mr, input logic bt, input ctl_t e, input logic ill);
    cyc_t c; c.op = op; c.mr = mr; c.bt = bt; c.e = e; c.ill = ill; q.push_back(c);
  endtask

  // expected cycle-by-cycle trace of one instruction
  task automatic instr(input logic [6:0] op, input int fw, input int mw, input logic bt);
    ctl_t c;
    for (int i = 0; i < fw; i++) push(op, 1'b0, bt, p_fetch(1'b0), 1'b0);
    push(op, 1'b1, bt, p_fetch(1'b1), 1'b0);
    push(op, 1'b1, bt, p_decode(op), 1'b0);
    case (op)
      R_OP:  begin push(op, 1'b1, bt, p_alu(2'b10, 2'b00, 2'b01, 3'b000), 1'b0); push(op, 1'b1, bt, p_wb(2'b00), 1'b0); end
      I_OP:  begin push(op, 1'b1, bt, p_alu(2'b10, 2'b01, 2'b10, 3'b000), 1'b0); push(op, 1'b1, bt, p_wb(2'b00), 1'b0); end
      LW_OP: begin
        push(op, 1'b1, bt, p_addr(op), 1'b0);
        c = '0; c.adr = 1'b1;
        for (int i = 0; i < mw; i++) push(op, 1'b0, bt, c, 1'b0);
        push(op, 1'b1, bt, c, 1'b0);
        push(op, 1'b1, bt, p_wb(2'b01), 1'b0);
      end
      S_OP: begin
        push(op, 1'b1, bt, p_addr(op), 1'b0);
        c = '0; c.adr = 1'b1; c.memw = 1'b1;
        for (int i = 0; i < mw; i++) push(op, 1'b0, bt, c, 1'b0);
        c.ret = 1'b1;
        push(op, 1'b1, bt, c, 1'b0);
      end
      B_OP: begin
        c = p_alu(2'b10, 2'b00, 2'b11, 3'b000); c.pcw = bt; c.ret = 1'b1;
        push(op, 1'b1, bt, c, 1'b0);
      end
      JAL_OP, JR_OP: begin
        if (op == JR_OP) push(op, 1'b1, bt, p_alu(2'b10, 2'b01, 2'b00, 3'b000), 1'b0);
        c = p_alu(2'b01, 2'b10, 2'b00, 3'b000); c.pcw = 1'b1;
        push(op, 1'b1, bt, c, 1'b0);
        push(op, 1'b1, bt, p_wb(2'b00), 1'b0);
      end
      LUI_OP: push(op, 1'b1, bt, p_wb(2'b11), 1'b0);
      default: begin
`ifdef ILLEGAL_OP_TRAP_EN
        for (int i = 0; i < 4; i++) push(op, 1'b1, bt, '0, 1'b1);
`endif
      end
    endcase
  endtask

  // replays the queue, comparing every cycle; returns cycle index of first DUT retire
  task automatic play(output int ret_at);
    cyc_t c;
    ctl_t act;
    int n = 0;
    ret_at = 0;
    while (q.size() > 0) begin
      c = q.pop_front();
      @(negedge clk);
      Op = c.op; mem_ready = c.mr; branch_taken = c.bt;
      #2;
      n++;
      act = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, RegWrite, retire};
      chk("ctl", 32'(act), 32'(c.e));
      chk("instret", 32'(instret), 32'(cnt));
`ifdef ILLEGAL_OP_TRAP_EN
      chk("illegal_op", 32'(illegal_op), 32'(c.ill));
`endif
      if (retire && ret_at == 0) ret_at = n;
      if (c.e.ret) cnt = (cnt + 1) % (1 << W);
    end
  endtask

  initial begin
    rst = 1'b1; Op = R_OP; branch_taken = 1'b0; mem_ready = 1'b1;
    #3;
    chk("reset_strobes", {PCWrite, IRWrite, MemWrite, RegWrite, retire}, 5'b0);
    chk("reset_instret", 32'(instret), 32'd0);
    mem_ready = 1'b0;
    @(negedge clk); rst = 1'b0;

    instr(R_OP, 0, 0, 1'b0); play(r);
    chk("add_cycles", r, 4);
    @(posedge clk); #1;
    chk("add_instret", 32'(instret), 32'd1);

    instr(LW_OP, 0, 3, 1'b0); play(r);
    chk("lw_cycles", r, 8);
    instr(B_OP, 0, 0, 1'b0); play(r);
    chk("beq_nt_cycles", r, 3);
    instr(B_OP, 0, 0, 1'b1); play(r);
    chk("beq_t_cycles", r, 3);
    instr(JR_OP, 0, 0, 1'b0); play(r);
    chk("jalr_cycles", r, 5);
    @(posedge clk); #1;
    chk("five_instret", 32'(instret), 32'd5);

    instr(I_OP, 2, 0, 1'b0);   play(r);
    instr(S_OP, 1, 2, 1'b0);   play(r);
    instr(JAL_OP, 0, 0, 1'b1); play(r);
    instr(LUI_OP, 0, 0, 1'b0); play(r);

    for (int i = 0; i < 10; i++) begin
      instr((i % 2 == 0) ? R_OP : LUI_OP, i % 3, 0, 1'b0);
      play(r);
    end
    @(posedge clk); #1;
    chk("wrap_instret", 32'(instret), 32'd3);

    instr(BAD_OP, 0, 0, 1'b0); play(r);
    chk("bad_no_retire", r, 0);
`ifdef ILLEGAL_OP_TRAP_EN
    rst = 1'b1; mem_ready = 1'b0; #1;
    chk("trap_cleared", 32'(illegal_op), 32'd0);
    cnt = 0;
    @(posedge clk); #1; rst = 1'b0;
`endif

    instr(R_OP, 0, 0, 1'b0); play(r);
    push(S_OP, 1'b1, 1'b0, p_fetch(1'b1), 1'b0);
    push(S_OP, 1'b1, 1'b0, p_decode(S_OP), 1'b0);
    push(S_OP, 1'b1, 1'b0, p_addr(S_OP), 1'b0);
    push(S_OP, 1'b0, 1'b0, ctl_t'(17'b0110_00_00_00_00_000_0_0), 1'b0);
    push(S_OP, 1'b0, 1'b0, ctl_t'(17'b0110_00_00_00_00_000_0_0), 1'b0);
    play(r);
    rst = 1'b1; #1;
    chk("rst_memwrite", 32'(MemWrite), 32'd0);
    chk("rst_mid_instret", 32'(instret), 32'd0);
    chk("rst_mid_strobes", {PCWrite, IRWrite, RegWrite, retire}, 4'b0);
    cnt = 0;
    @(posedge clk); #1; rst = 1'b0;
    instr(R_OP, 0, 0, 1'b0); play(r);
    chk("post_rst_cycles", r, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
